// File: rtl/rd_circ_buf_reader.sv
// rtl/rd_circ_buf_reader.sv - circular-buffer read: splits wrapped reads into two memory reads, repacks to one NoC stream
// Optional feature macro: RD_CIRC_BUF_RESP_CHECK_EN (memory last/padbytes checking, sticky rd_buf_resp_err).

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef NOC_DATA_BYTES
`define NOC_DATA_BYTES 64
`endif
`ifndef NOC_PADBYTES_WIDTH
`define NOC_PADBYTES_WIDTH 6
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif

package rd_circ_buf_pkg;
    localparam int FLOWID_W   = 8;
    localparam int MEM_ADDR_W = 32;
    typedef struct packed {
        logic [MEM_ADDR_W-1:0]           addr;
        logic [`MSG_DATA_SIZE_WIDTH-1:0] size;
    } mem_req_struct;
endpackage

module rd_circ_buf_reader
    import rd_circ_buf_pkg::*;
#(
    parameter int BUF_PTR_W = 14
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            src_rd_buf_req_val,
    input  logic [FLOWID_W-1:0]             src_rd_buf_req_flowid,
    input  logic [BUF_PTR_W-1:0]            src_rd_buf_req_rd_ptr,
    input  logic [`MSG_DATA_SIZE_WIDTH-1:0] src_rd_buf_req_size,
    output logic                            rd_buf_src_req_rdy,
    output logic                            rd_buf_rd_mem_req_val,
    output mem_req_struct                   rd_buf_rd_mem_req,
    input  logic                            rd_mem_rd_buf_req_rdy,
    input  logic                            rd_mem_rd_buf_resp_data_val,
    input  logic [`NOC_DATA_WIDTH-1:0]      rd_mem_rd_buf_resp_data,
    input  logic                            rd_mem_rd_buf_resp_data_last,
    input  logic [`NOC_PADBYTES_WIDTH-1:0]  rd_mem_rd_buf_resp_data_padbytes,
    output logic                            rd_buf_rd_mem_resp_data_rdy,
    output logic                            rd_buf_dst_resp_data_val,
    output logic [`NOC_DATA_WIDTH-1:0]      rd_buf_dst_resp_data,
    output logic                            rd_buf_dst_resp_data_last,
    output logic [`NOC_PADBYTES_WIDTH-1:0]  rd_buf_dst_resp_data_padbytes,
    input  logic                            dst_rd_buf_resp_data_rdy,
    output logic                            rd_buf_resp_err
);
    localparam int DW = `NOC_DATA_WIDTH;
    localparam int PW = `NOC_PADBYTES_WIDTH;
    localparam int SW = `MSG_DATA_SIZE_WIDTH;
    localparam logic [SW-1:0] B_SZ = SW'(`NOC_DATA_BYTES);

    typedef enum logic [2:0] {IDLE, REQ0, DATA0, REQ1, DATA1, FLUSH} state_t;

    state_t               state, state_next;
    logic [FLOWID_W-1:0]  flowid_r;
    logic [BUF_PTR_W-1:0] ptr_r;
    logic                 split_r;
    logic [SW-1:0]        l0_r, l1_r, in_rem, out_rem;
    logic [DW-1:0]        save_line;
    logic [PW-1:0]        save_k;

    logic [BUF_PTR_W:0]   bytes_to_end;
    logic                 split_c;
    logic [SW-1:0]        l0_c;
    logic                 in_final, out_last, save_now, mem_xfer, dst_xfer;
    logic [PW-1:0]        in_k;
    logic [SW-1:0]        out_bytes;

    function automatic logic [DW-1:0] top_mask(input int nbytes);
        logic [DW-1:0] ones;
        ones = '1;
        return ~(ones >> (8 * nbytes));
    endfunction

    assign bytes_to_end = {1'b1, {BUF_PTR_W{1'b0}}} - {1'b0, src_rd_buf_req_rd_ptr};
    assign split_c      = src_rd_buf_req_size > SW'(bytes_to_end);
    assign l0_c         = split_c ? SW'(bytes_to_end) : src_rd_buf_req_size;
    assign in_final     = in_rem <= B_SZ;
    assign out_last     = out_rem <= B_SZ;
    assign in_k         = in_rem[PW-1:0];
    assign out_bytes    = out_last ? out_rem : B_SZ;
    // A short tail of segment 0 is parked and merged into segment 1 instead of being emitted.
    assign save_now     = (state == DATA0) && in_final && split_r && (in_k != '0);
    assign mem_xfer     = rd_mem_rd_buf_resp_data_val && rd_buf_rd_mem_resp_data_rdy;
    assign dst_xfer     = rd_buf_dst_resp_data_val && dst_rd_buf_resp_data_rdy;

    always_comb begin
        state_next                  = state;
        rd_buf_src_req_rdy          = 1'b0;
        rd_buf_rd_mem_req_val       = 1'b0;
        rd_buf_rd_mem_req           = '0;
        rd_buf_rd_mem_resp_data_rdy = 1'b0;
        rd_buf_dst_resp_data_val    = 1'b0;
        rd_buf_dst_resp_data        = '0;
        rd_buf_dst_resp_data_last   = 1'b0;
        case (state)
            IDLE: begin
                rd_buf_src_req_rdy = 1'b1;
                if (src_rd_buf_req_val && (src_rd_buf_req_size != '0)) state_next = REQ0;
            end
            REQ0: begin
                rd_buf_rd_mem_req_val  = 1'b1;
                rd_buf_rd_mem_req.addr = MEM_ADDR_W'({flowid_r, ptr_r});
                rd_buf_rd_mem_req.size = l0_r;
                if (rd_mem_rd_buf_req_rdy) state_next = DATA0;
            end
            DATA0: begin
                if (save_now) begin
                    rd_buf_rd_mem_resp_data_rdy = 1'b1;
                    if (rd_mem_rd_buf_resp_data_val) state_next = REQ1;
                end else begin
                    rd_buf_dst_resp_data_val    = rd_mem_rd_buf_resp_data_val;
                    rd_buf_rd_mem_resp_data_rdy = dst_rd_buf_resp_data_rdy;
                    rd_buf_dst_resp_data        = rd_mem_rd_buf_resp_data & top_mask(int'(out_bytes));
                    rd_buf_dst_resp_data_last   = out_last;
                    if (rd_mem_rd_buf_resp_data_val && dst_rd_buf_resp_data_rdy && in_final)
                        state_next = split_r ? REQ1 : IDLE;
                end
            end
            REQ1: begin
                rd_buf_rd_mem_req_val  = 1'b1;
                rd_buf_rd_mem_req.addr = MEM_ADDR_W'({flowid_r, {BUF_PTR_W{1'b0}}});
                rd_buf_rd_mem_req.size = l1_r;
                if (rd_mem_rd_buf_req_rdy) state_next = DATA1;
            end
            DATA1: begin
                rd_buf_dst_resp_data_val    = rd_mem_rd_buf_resp_data_val;
                rd_buf_rd_mem_resp_data_rdy = dst_rd_buf_resp_data_rdy;
                rd_buf_dst_resp_data        = ((save_k == '0) ? rd_mem_rd_buf_resp_data :
                                               (save_line | (rd_mem_rd_buf_resp_data >> (8 * int'(save_k)))))
                                              & top_mask(int'(out_bytes));
                rd_buf_dst_resp_data_last   = out_last;
                if (rd_mem_rd_buf_resp_data_val && dst_rd_buf_resp_data_rdy && in_final)
                    state_next = out_last ? IDLE : FLUSH;
            end
            FLUSH: begin
                rd_buf_dst_resp_data_val  = 1'b1;
                rd_buf_dst_resp_data      = save_line & top_mask(int'(out_bytes));
                rd_buf_dst_resp_data_last = 1'b1;
                if (dst_rd_buf_resp_data_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_buf_dst_resp_data_padbytes = rd_buf_dst_resp_data_last ? PW'(B_SZ - out_rem) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flowid_r  <= '0;
            ptr_r     <= '0;
            split_r   <= 1'b0;
            l0_r      <= '0;
            l1_r      <= '0;
            in_rem    <= '0;
            out_rem   <= '0;
            save_line <= '0;
            save_k    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (src_rd_buf_req_val) begin
                    flowid_r <= src_rd_buf_req_flowid;
                    ptr_r    <= src_rd_buf_req_rd_ptr;
                    split_r  <= split_c;
                    l0_r     <= l0_c;
                    l1_r     <= src_rd_buf_req_size - l0_c;
                    out_rem  <= src_rd_buf_req_size;
                    save_k   <= '0;
                end
                REQ0: if (rd_mem_rd_buf_req_rdy) in_rem <= l0_r;
                REQ1: if (rd_mem_rd_buf_req_rdy) in_rem <= l1_r;
                default: ;
            endcase
            if (mem_xfer) in_rem <= in_final ? '0 : in_rem - B_SZ;
            if (dst_xfer) out_rem <= out_last ? '0 : out_rem - B_SZ;
            if (save_now && rd_mem_rd_buf_resp_data_val) begin
                save_line <= rd_mem_rd_buf_resp_data & top_mask(int'(in_k));
                save_k    <= in_k;
            end
            // Bytes of this line not yet emitted become the left-aligned head of the next line.
            if (dst_xfer && (state == DATA1) && (save_k != '0))
                save_line <= rd_mem_rd_buf_resp_data << (8 * (`NOC_DATA_BYTES - int'(save_k)));
        end
    end

`ifdef RD_CIRC_BUF_RESP_CHECK_EN
    logic err_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (mem_xfer) begin
            if ((rd_mem_rd_buf_resp_data_last != in_final) ||
                (in_final && (rd_mem_rd_buf_resp_data_padbytes != PW'(B_SZ - in_rem))))
                err_r <= 1'b1;
        end
    end
    assign rd_buf_resp_err = err_r;
`else
    logic unused_resp_sigs;
    assign unused_resp_sigs = ^{rd_mem_rd_buf_resp_data_last, rd_mem_rd_buf_resp_data_padbytes};
    assign rd_buf_resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rd_circ_buf_reader.sv
// tb/tb_rd_circ_buf_reader.sv - directed self-checking bench for rd_circ_buf_reader
module tb_rd_circ_buf_reader;
    import rd_circ_buf_pkg::*;

    localparam int B      = 64;
    localparam int DW     = 512;
    localparam int PW     = 6;
    localparam int SW     = 16;
    localparam int PTR_W  = 14;
    localparam int BUF_SZ = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                src_val = 1'b0;
    logic [FLOWID_W-1:0] src_flowid = '0;
    logic [PTR_W-1:0]    src_ptr = '0;
    logic [SW-1:0]       src_size = '0;
    logic                src_rdy;
    logic                mem_req_val;
    mem_req_struct       mem_req;
    logic                mem_req_rdy = 1'b0;
    logic                mem_val = 1'b0;
    logic [DW-1:0]       mem_data = '0;
    logic                mem_last = 1'b0;
    logic [PW-1:0]       mem_pad = '0;
    logic                mem_rdy;
    logic                dst_val;
    logic [DW-1:0]       dst_data;
    logic                dst_last;
    logic [PW-1:0]       dst_pad;
    logic                dst_rdy = 1'b1;
    logic                err;

    rd_circ_buf_reader #(.BUF_PTR_W(PTR_W)) dut (
        .clk                              (clk),
        .rst                              (rst),
        .src_rd_buf_req_val               (src_val),
        .src_rd_buf_req_flowid            (src_flowid),
        .src_rd_buf_req_rd_ptr            (src_ptr),
        .src_rd_buf_req_size              (src_size),
        .rd_buf_src_req_rdy               (src_rdy),
        .rd_buf_rd_mem_req_val            (mem_req_val),
        .rd_buf_rd_mem_req                (mem_req),
        .rd_mem_rd_buf_req_rdy            (mem_req_rdy),
        .rd_mem_rd_buf_resp_data_val      (mem_val),
        .rd_mem_rd_buf_resp_data          (mem_data),
        .rd_mem_rd_buf_resp_data_last     (mem_last),
        .rd_mem_rd_buf_resp_data_padbytes (mem_pad),
        .rd_buf_rd_mem_resp_data_rdy      (mem_rdy),
        .rd_buf_dst_resp_data_val         (dst_val),
        .rd_buf_dst_resp_data             (dst_data),
        .rd_buf_dst_resp_data_last        (dst_last),
        .rd_buf_dst_resp_data_padbytes    (dst_pad),
        .dst_rd_buf_resp_data_rdy         (dst_rdy),
        .rd_buf_resp_err                  (err)
    );

    typedef struct {
        int ptr; int size; bit rnd; int nreq;
        int p0; int s0; int p1; int s1; int nlines; int pad;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] out_data_q[$];
    logic          out_last_q[$];
    logic [PW-1:0] out_pad_q[$];
    logic [31:0]   req_addr_q[$];
    int            req_size_q[$];
    vec_t          vecs[10];

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int a);
        return 8'(a * 37 + (a >> 7) + 11);
    endfunction

    function automatic logic [DW-1:0] mem_line(input int p, input int sz, input int j);
        logic [DW-1:0] l;
        l = '0;
        for (int i = 0; i < B; i++)
            l[DW-1-8*i -: 8] = (j * B + i < sz) ? byte_at(p + j * B + i) : 8'hEE;
        return l;
    endfunction

    function automatic logic [DW-1:0] exp_line(input int p, input int sz, input int j);
        logic [DW-1:0] l;
        l = '0;
        for (int i = 0; i < B; i++)
            if (j * B + i < sz) l[DW-1-8*i -: 8] = byte_at((p + j * B + i) % BUF_SZ);
        return l;
    endfunction

    // Wait tasks start after inputs are driven at a negedge and return just before the transfer edge.
    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #4;
            if (mem_req_val) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic wait_mem_rdy(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            #4;
            if (mem_rdy) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic mem_serve(input int nreq, input bit bad_pad);
        bit ok;
        for (int r = 0; r < nreq; r++) begin
            int p, sz, nl;
            mem_req_rdy = 1'b1;
            wait_mem_req(ok);
            if (!ok) begin
                check_eq("mem_req_timeout", 0, 1);
                mem_req_rdy = 1'b0;
                return;
            end
            req_addr_q.push_back(mem_req.addr);
            req_size_q.push_back(int'(mem_req.size));
            p  = int'(mem_req.addr[PTR_W-1:0]);
            sz = int'(mem_req.size);
            nl = (sz + B - 1) / B;
            @(negedge clk);
            mem_req_rdy = 1'b0;
            for (int j = 0; j < nl; j++) begin
                mem_val  = 1'b1;
                mem_data = mem_line(p, sz, j);
                mem_last = (j == nl - 1);
                mem_pad  = (j == nl - 1) ? PW'(nl * B - sz) : '0;
                if (bad_pad && (j == nl - 1)) mem_pad = mem_pad ^ 6'd1;
                wait_mem_rdy(ok);
                if (!ok) begin
                    check_eq("mem_data_timeout", 0, 1);
                    mem_val = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            mem_val  = 1'b0;
            mem_last = 1'b0;
            mem_pad  = '0;
        end
    endtask

    task automatic collect(input bit rnd, input int p, input int sz);
        bit prev_stall = 1'b0;
        for (int c = 0; c < 600; c++) begin
            dst_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (prev_stall) begin
                check_eq("hold_val", dst_val, 1);
                check_eq("hold_data", dst_data, exp_line(p, sz, out_data_q.size()));
            end
            if (dst_val && dst_rdy) begin
                out_data_q.push_back(dst_data);
                out_last_q.push_back(dst_last);
                out_pad_q.push_back(dst_pad);
                prev_stall = 1'b0;
                if (dst_last) begin
                    @(negedge clk);
                    dst_rdy = 1'b1;
                    return;
                end
            end else begin
                prev_stall = dst_val;
            end
            @(negedge clk);
        end
        dst_rdy = 1'b1;
        check_eq("collect_timeout", 0, 1);
    endtask

    task automatic run_case(input int idx, input vec_t v, input logic [7:0] flow, input bit bad_pad);
        bit ok;
        int seen;
        out_data_q.delete(); out_last_q.delete(); out_pad_q.delete();
        req_addr_q.delete(); req_size_q.delete();
        @(negedge clk);
        src_val = 1'b1; src_flowid = flow; src_ptr = PTR_W'(v.ptr); src_size = SW'(v.size);
        #4;
        ok = src_rdy;
        @(negedge clk);
        src_val = 1'b0;
        check_eq($sformatf("v%0d_req_rdy", idx), ok, 1);
        if (v.size == 0) begin
            seen = 0;
            repeat (20) begin
                #4;
                if (mem_req_val || dst_val || !src_rdy) seen++;
                @(negedge clk);
            end
            check_eq($sformatf("v%0d_zero_traffic", idx), seen, 0);
            return;
        end
        fork
            mem_serve(v.nreq, bad_pad);
            collect(v.rnd, v.ptr, v.size);
        join
        check_eq($sformatf("v%0d_nreq", idx), req_addr_q.size(), v.nreq);
        if (req_addr_q.size() > 0) begin
            check_eq($sformatf("v%0d_req0_addr", idx), req_addr_q[0], {10'd0, flow, 14'(v.p0)});
            check_eq($sformatf("v%0d_req0_size", idx), req_size_q[0], v.s0);
        end
        if (req_addr_q.size() > 1) begin
            check_eq($sformatf("v%0d_req1_addr", idx), req_addr_q[1], {10'd0, flow, 14'(v.p1)});
            check_eq($sformatf("v%0d_req1_size", idx), req_size_q[1], v.s1);
        end
        check_eq($sformatf("v%0d_nlines", idx), out_data_q.size(), v.nlines);
        for (int j = 0; j < out_data_q.size(); j++) begin
            check_eq($sformatf("v%0d_l%0d_data", idx, j), out_data_q[j], exp_line(v.ptr, v.size, j));
            check_eq($sformatf("v%0d_l%0d_last", idx, j), out_last_q[j], (j == v.nlines - 1));
            check_eq($sformatf("v%0d_l%0d_pad", idx, j), out_pad_q[j], (j == v.nlines - 1) ? v.pad : 0);
        end
    endtask

    task automatic reset_in_data1();
        bit ok;
        @(negedge clk);
        dst_rdy = 1'b0;
        src_val = 1'b1; src_flowid = 8'h33; src_ptr = 14'd16364; src_size = 16'd100;
        #4;
        @(negedge clk);
        src_val = 1'b0;
        mem_req_rdy = 1'b1;
        wait_mem_req(ok);
        check_eq("rst_t_req0_seen", ok, 1);
        @(negedge clk);
        mem_req_rdy = 1'b0;
        mem_val = 1'b1; mem_data = mem_line(16364, 20, 0); mem_last = 1'b1; mem_pad = 6'd44;
        wait_mem_rdy(ok);
        check_eq("rst_t_seg0_taken", ok, 1);
        @(negedge clk);
        mem_val = 1'b0;
        mem_req_rdy = 1'b1;
        wait_mem_req(ok);
        check_eq("rst_t_req1_seen", ok, 1);
        @(negedge clk);
        mem_req_rdy = 1'b0;
        mem_val = 1'b1; mem_data = mem_line(0, 80, 0); mem_last = 1'b0; mem_pad = '0;
        #4;
        check_eq("rst_t_data1_val", dst_val, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #4;
        check_eq("rst_t_req_rdy", src_rdy, 1);
        check_eq("rst_t_mem_req_val", mem_req_val, 0);
        check_eq("rst_t_mem_rdy", mem_rdy, 0);
        check_eq("rst_t_dst_val", dst_val, 0);
        check_eq("rst_t_last", dst_last, 0);
        check_eq("rst_t_pad", dst_pad, 0);
        check_eq("rst_t_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_val = 1'b0;
        dst_rdy = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,     128, 1'b0, 1, 0,     128, 0, 0,   2, 0};
        vecs[1] = '{100,   100, 1'b0, 1, 100,   100, 0, 0,   2, 28};
        vecs[2] = '{16320, 128, 1'b0, 2, 16320, 64,  0, 64,  2, 0};
        vecs[3] = '{16364, 100, 1'b0, 2, 16364, 20,  0, 80,  2, 28};
        vecs[4] = '{16344, 100, 1'b0, 2, 16344, 40,  0, 60,  2, 28};
        vecs[5] = '{16364, 100, 1'b1, 2, 16364, 20,  0, 80,  2, 28};
        vecs[6] = '{16383, 200, 1'b1, 2, 16383, 1,   0, 199, 4, 56};
        vecs[7] = '{16320, 64,  1'b0, 1, 16320, 64,  0, 0,   1, 0};
        vecs[8] = '{5,     1,   1'b0, 1, 5,     1,   0, 0,   1, 63};
        vecs[9] = '{0,     0,   1'b0, 0, 0,     0,   0, 0,   0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        check_eq("reset_req_rdy", src_rdy, 1);
        check_eq("reset_mem_req_val", mem_req_val, 0);
        check_eq("reset_mem_rdy", mem_rdy, 0);
        check_eq("reset_dst_val", dst_val, 0);
        check_eq("reset_last", dst_last, 0);
        check_eq("reset_pad", dst_pad, 0);
        check_eq("reset_err", err, 0);

        for (int i = 0; i < 10; i++) run_case(i, vecs[i], 8'(8'h5A + i), 1'b0);
        check_eq("err_clean", err, 0);

        run_case(10, vecs[1], 8'hC3, 1'b1);
`ifdef RD_CIRC_BUF_RESP_CHECK_EN
        check_eq("err_bad_pad", err, 1);
`else
        check_eq("err_tied_low", err, 0);
`endif

        reset_in_data1();
        run_case(11, vecs[3], 8'h11, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
